// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detectors: state-width helper and
// the state width of the default four-bit pattern.
package seq_detector_pkg;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  localparam int PAT_W_DEF = 4;
  localparam int SW        = clog2(PAT_W_DEF + 1);

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational KMP-style next state: longest prefix of the pattern that is a
// suffix of (matched prefix of length cs_i, then x_i), capped at PAT_W.
module seq_prefix_match
  import seq_detector_pkg::*;
#(
  parameter int  PAT_W = 4,
  localparam int STW   = clog2(PAT_W + 1)
) (
  input  logic [STW-1:0]   cs_i,
  input  logic             x_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic [STW-1:0]   ns_o
);

  logic [PAT_W:0] pat_ext;
  logic [PAT_W:0] seq;
  logic [PAT_W:0] mask;
  logic [PAT_W:0] head;
  int             best;

  always_comb begin
    pat_ext = {1'b0, pattern_i};
    // The matched prefix is the first cs_i pattern bits; append x_i as the LSB.
    seq     = ((pat_ext >> (PAT_W - int'(cs_i))) << 1) | {{PAT_W{1'b0}}, x_i};
    best    = 0;
    mask    = '0;
    head    = '0;
    for (int l = 1; l <= PAT_W; l++) begin
      mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - l);
      head = pat_ext >> (PAT_W - l);
      if ((l <= int'(cs_i) + 1) && ((seq & mask) == head)) best = l;
    end
    ns_o = STW'(best);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with registered match pulse.
// Optional saturating match counter enabled by `define SEQDET_MATCH_CNT_EN.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  localparam int              STW     = clog2(PAT_W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           x,
  input  logic           x_valid,
  output logic           y,
  output logic [STW-1:0] cs,
  output logic [STW-1:0] ns
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [STW-1:0] FULL = STW'(PAT_W);

  logic [STW-1:0] cs_q;
  logic [STW-1:0] ns_d;
  logic [STW-1:0] base_cs;
  logic [STW-1:0] match_ns;
  logic           y_q;
  logic           hit;

  // Without overlap a completed match restarts from the empty prefix.
  always_comb begin
    base_cs = cs_q;
    if ((cs_q == FULL) && !OVERLAP) base_cs = '0;
  end

  seq_prefix_match #(.PAT_W(PAT_W)) u_match (
    .cs_i      (base_cs),
    .x_i       (x),
    .pattern_i (PATTERN),
    .ns_o      (match_ns)
  );

  always_comb begin
    ns_d = cs_q;
    if (x_valid) ns_d = match_ns;
  end

  assign hit = x_valid && (ns_d == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q <= '0;
      y_q  <= 1'b0;
    end else begin
      cs_q <= ns_d;
      y_q  <= hit;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`endif

  assign y  = y_q;
  assign cs = cs_q;
  assign ns = ns_d;

endmodule
